// File: rtl/error_vec_builder.sv
// error_vec_builder: collects sparse error positions 0..2R-1 into dense halves e0/e1
// until T distinct bits are set, then pulses done for one cycle with e0/e1 final.
// Latency: done is high the cycle after the T-th distinct position is accepted.
// Backpressure: pos_ready is high only while collecting; one beat per cycle, never stalls.
// Optional macro ERRVEC_REJ_STATS_EN enables the saturating rejected-beat counter rej_cnt;
// when undefined rej_cnt is tied to 0.
// Ports: clk/rst (sync, active-high); start; pos_in/pos_valid/pos_ready beat handshake;
//        e0/e1 dense halves; weight accepted count; busy; done pulse; rej_cnt.
module error_vec_builder #(
  parameter int R     = 127,
  parameter int T     = 8,
  parameter int POS_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [POS_W-1:0] pos_in,
  input  logic             pos_valid,
  output logic             pos_ready,
  output logic [R-1:0]     e0,
  output logic [R-1:0]     e1,
  output logic [CNT_W-1:0] weight,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rej_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // 2R can equal 2^POS_W, so the range bound needs one extra bit.
  localparam logic [POS_W:0]   TWO_R = (POS_W+1)'(2*R);
  localparam logic [POS_W-1:0] R_POS = POS_W'(R);

  state_t           state, state_nxt;
  logic             in_range;
  logic             is_low;
  logic [POS_W-1:0] e1_idx;
  logic [R-1:0]     hit0;
  logic [R-1:0]     hit1;
  logic             dup;
  logic             beat;
  logic             accept;
  logic             clear;

  // Decode the candidate position into one-hot masks for each half.
  always_comb begin
    in_range = {1'b0, pos_in} < TWO_R;
    is_low   = pos_in < R_POS;
    e1_idx   = pos_in - R_POS;
    hit0     = '0;
    hit1     = '0;
    for (int i = 0; i < R; i++) begin
      hit0[i] = is_low && (pos_in == POS_W'(i));
      // is_low must be excluded: pos_in - R wraps for low positions.
      hit1[i] = in_range && !is_low && (e1_idx == POS_W'(i));
    end
    dup    = (|(hit0 & e0)) || (|(hit1 & e1));
    beat   = (state == S_COLLECT) && pos_valid;
    accept = beat && in_range && !dup;
    clear  = (state == S_IDLE) && start;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pos_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        pos_ready = 1'b1;
        busy      = 1'b1;
        if (accept && (weight == CNT_W'(T-1))) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // e0/e1/weight keep the last result in IDLE until a new start clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      e0     <= '0;
      e1     <= '0;
      weight <= '0;
    end else if (clear) begin
      e0     <= '0;
      e1     <= '0;
      weight <= '0;
    end else if (accept) begin
      e0     <= e0 | hit0;
      e1     <= e1 | hit1;
      weight <= weight + CNT_W'(1);
    end
  end

`ifdef ERRVEC_REJ_STATS_EN
  logic reject;
  assign reject = beat && !accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      rej_cnt <= '0;
    end else if (clear) begin
      rej_cnt <= '0;
    end else if (reject && (rej_cnt != 8'hFF)) begin
      rej_cnt <= rej_cnt + 8'd1;
    end
  end
`else
  assign rej_cnt = '0;
`endif

endmodule

// File: tb/tb_error_vec_builder.sv
// Testbench for error_vec_builder (R=127, T=4): table-driven vectors, hand sequences
// for reset / idle beats / saturation, and randomized builds against a set-based model.
module tb_error_vec_builder;
  localparam int R     = 127;
  localparam int T     = 4;
  localparam int POS_W = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [POS_W-1:0] pos_in;
  logic             pos_valid;
  logic             pos_ready;
  logic [R-1:0]     e0;
  logic [R-1:0]     e1;
  logic [CNT_W-1:0] weight;
  logic             busy;
  logic             done;
  logic [7:0]       rej_cnt;

  int vectors = 0;
  int fails   = 0;

  error_vec_builder #(.R(R), .T(T), .POS_W(POS_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pos_in(pos_in), .pos_valid(pos_valid),
    .pos_ready(pos_ready), .e0(e0), .e1(e1), .weight(weight), .busy(busy),
    .done(done), .rej_cnt(rej_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int pos[9];
    bit vld[9];
    int e0b[4];
    int e1b[4];
    int rej;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [R-1:0] mk(input int b[4]);
    logic [R-1:0] v = '0;
    for (int i = 0; i < 4; i++) if (b[i] >= 0) v[b[i]] = 1'b1;
    return v;
  endfunction

  function automatic int exp_rej(input int raw);
`ifdef ERRVEC_REJ_STATS_EN
    return (raw > 255) ? 255 : raw;
`else
    return 0 * raw;
`endif
  endfunction

  // Runs one build: start, then the beat list; checks done/pos_ready timing each cycle
  // against a set-based model and returns the model's final vector.
  task automatic build(input int pos[$], input bit vld[$], input bit hold_start,
                       output logic [R-1:0] m_e0, output logic [R-1:0] m_e1,
                       output int m_rej, output int m_wt);
    bit seen[2*R];
    int cnt  = 0;
    bit fin  = 0;
    bit just = 0;
    m_rej = 0;
    for (int i = 0; i < 2*R; i++) seen[i] = 0;
    @(negedge clk);
    start = 1'b1; pos_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < pos.size(); k++) begin
      chk("done_timing", done, just);
      chk("pos_ready", pos_ready, !fin);
      start     = hold_start && (!fin || just);
      pos_in    = pos[k][POS_W-1:0];
      pos_valid = vld[k];
      just      = 0;
      if (!fin && vld[k]) begin
        if (pos[k] < 2*R && !seen[pos[k]]) begin
          seen[pos[k]] = 1;
          cnt++;
          if (cnt == T) begin fin = 1; just = 1; end
        end else begin
          m_rej++;
        end
      end
      @(negedge clk);
    end
    chk("done_timing", done, just);
    chk("pos_ready", pos_ready, !fin);
    chk("finished", fin, 1'b1);
    pos_valid = 1'b0;
    start     = hold_start && just;
    @(negedge clk);
    start = 1'b0;
    chk("done_once", done, 1'b0);
    chk("busy_idle", busy, 1'b0);
    m_e0 = '0; m_e1 = '0;
    for (int i = 0; i < R; i++) begin
      m_e0[i] = seen[i];
      m_e1[i] = seen[i+R];
    end
    m_wt = cnt;
  endtask

  task automatic chk_result(input logic [R-1:0] x0, input logic [R-1:0] x1, input int rej);
    chk("e0", e0, x0);
    chk("e1", e1, x1);
    chk("weight", weight, T);
    chk("rej_cnt", rej_cnt, exp_rej(rej));
  endtask

  initial begin
    vec_t         tbl[4];
    int           pq[$];
    bit           vq[$];
    logic [R-1:0] me0, me1;
    int           mrej, mwt;

    tbl[0] = '{4, '{3,130,126,200,0,0,0,0,0}, '{1,1,1,1,0,0,0,0,0},
               '{3,126,-1,-1}, '{3,73,-1,-1}, 0};
    tbl[1] = '{6, '{5,5,130,5,9,250,0,0,0}, '{1,1,1,1,1,1,0,0,0},
               '{5,9,-1,-1}, '{3,123,-1,-1}, 2};
    tbl[2] = '{6, '{254,255,0,253,127,128,0,0,0}, '{1,1,1,1,1,1,0,0,0},
               '{0,-1,-1,-1}, '{126,0,1,-1}, 2};
    tbl[3] = '{9, '{10,99,99,20,77,30,40,50,60}, '{1,0,0,1,0,1,1,0,1},
               '{10,20,30,40}, '{-1,-1,-1,-1}, 0};

    rst = 1'b1; start = 1'b0; pos_in = '0; pos_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_e0", e0, '0);
    chk("rst_e1", e1, '0);
    chk("rst_weight", weight, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", pos_ready, 1'b0);
    chk("rst_rej", rej_cnt, '0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, each once normally and once with start held high.
    for (int hs = 0; hs < 2; hs++) begin
      for (int v = 0; v < 4; v++) begin
        pq.delete(); vq.delete();
        for (int i = 0; i < tbl[v].n; i++) begin
          pq.push_back(tbl[v].pos[i]);
          vq.push_back(tbl[v].vld[i]);
        end
        build(pq, vq, hs[0], me0, me1, mrej, mwt);
        chk_result(mk(tbl[v].e0b), mk(tbl[v].e1b), tbl[v].rej);
      end
    end

    // Beats offered in IDLE are not taken and the last result is held.
    pos_valid = 1'b1; pos_in = 8'd77;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", pos_ready, 1'b0);
    end
    pos_valid = 1'b0;
    chk_result(mk(tbl[3].e0b), mk(tbl[3].e1b), 0);

    // Reset after two accepted beats.
    start = 1'b1; @(negedge clk);
    start = 1'b0; pos_valid = 1'b1; pos_in = 8'd7; @(negedge clk);
    pos_in = 8'd140; @(negedge clk);
    chk("mid_weight", weight, 2);
    pos_in = 8'd9; rst = 1'b1; @(negedge clk);
    rst = 1'b0; pos_valid = 1'b0;
    chk("mrst_e0", e0, '0);
    chk("mrst_e1", e1, '0);
    chk("mrst_weight", weight, '0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_ready", pos_ready, 1'b0);
    chk("mrst_rej", rej_cnt, '0);
    repeat (3) begin
      chk("mrst_nodone", done, 1'b0);
      @(negedge clk);
    end
    pq.delete(); vq.delete();
    for (int i = 0; i < tbl[0].n; i++) begin pq.push_back(tbl[0].pos[i]); vq.push_back(1); end
    build(pq, vq, 1'b0, me0, me1, mrej, mwt);
    chk_result(mk(tbl[0].e0b), mk(tbl[0].e1b), 0);

    // Rejected-beat counter saturation: 300 out-of-range beats then 4 good ones.
    pq.delete(); vq.delete();
    for (int i = 0; i < 300; i++) begin pq.push_back(255); vq.push_back(1); end
    for (int i = 1; i <= 4; i++) begin pq.push_back(i * 50); vq.push_back(1); end
    build(pq, vq, 1'b0, me0, me1, mrej, mwt);
    chk_result(me0, me1, mrej);
    chk("sat_rej", rej_cnt, exp_rej(300));

    // Randomized builds against the model.
    for (int r = 0; r < 40; r++) begin
      pq.delete(); vq.delete();
      for (int i = 0; i < 80; i++) begin
        if ($urandom_range(0, 2) == 0) pq.push_back($urandom_range(0, 5));
        else                           pq.push_back($urandom_range(0, 255));
        vq.push_back($urandom_range(0, 3) != 0);
      end
      build(pq, vq, $urandom_range(0, 1) == 1, me0, me1, mrej, mwt);
      chk("rnd_wt_model", mwt, T);
      chk_result(me0, me1, mrej);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
